// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry add/subtract with valid/ready handshake; one CHUNK-bit slice per stage.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d), 1 <= STAGES <= WIDTH",
               WIDTH, STAGES);
    end

    logic [STAGES-1:0] valid;
    logic [STAGES:0]   ready;

    // A stage may advance when it is empty or its successor is advancing.
    always_comb begin
        ready[STAGES] = out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            ready[STAGES-1-i] = !valid[STAGES-1-i] || ready[STAGES-i];
        end
    end

    assign in_ready = ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet consumed on entry to this stage.
        localparam int unsigned REM = WIDTH - k * CHUNK;

        logic                     v_src;
        logic                     c_src;
        logic [REM-1:0]           a_src;
        logic [REM-1:0]           b_src;
        logic [CHUNK:0]           add;
        logic [(k+1)*CHUNK-1:0]   s_next;
        logic                     v_q;
        logic                     c_q;
        logic [(k+1)*CHUNK-1:0]   s_q;

        assign add = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_src};

        if (k == 0) begin : g_head
            assign v_src  = in_valid;
            assign a_src  = a;
            assign b_src  = sub ? ~b : b;
            assign c_src  = sub | cin;
            assign s_next = add[CHUNK-1:0];
        end else begin : g_body
            assign v_src  = g_stage[k-1].v_q;
            assign a_src  = g_stage[k-1].g_pass.a_q;
            assign b_src  = g_stage[k-1].g_pass.b_q;
            assign c_src  = g_stage[k-1].c_q;
            assign s_next = {add[CHUNK-1:0], g_stage[k-1].s_q};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (ready[k]) begin
                v_q <= v_src;
                c_q <= add[CHUNK];
                s_q <= s_next;
            end
        end

        if (k < STAGES - 1) begin : g_pass
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;

            always_ff @(posedge clk) begin
                if (ready[k]) begin
                    a_q <= a_src[REM-1:CHUNK];
                    b_q <= b_src[REM-1:CHUNK];
                end
            end
        end

`ifdef PIPELINED_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic msb_carry_in;
            logic ovf_q;

            // Sum bit = a ^ b ^ carry-in, so the carry into the MSB is recovered from the result.
            assign msb_carry_in = a_src[CHUNK-1] ^ b_src[CHUNK-1] ^ add[CHUNK-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (ready[k]) begin
                    ovf_q <= msb_carry_in ^ add[CHUNK];
                end
            end

            assign ovf = ovf_q;
        end
`endif

        assign valid[k] = v_q;
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: 8-bit/2-stage vector table plus a 32-bit/4-stage instance with scoreboard.
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Narrow instance
    logic       s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready, s_cout;
    logic [7:0] s_a, s_b, s_sum;
`ifdef PIPELINED_ADDER_OVF_EN
    logic       s_ovf;
`endif

    // Wide instance
    logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout;
    logic [31:0] w_a, w_b, w_sum;
`ifdef PIPELINED_ADDER_OVF_EN
    logic        w_ovf;
`endif

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .sum(s_sum),
`ifdef PIPELINED_ADDER_OVF_EN
        .ovf(s_ovf),
`endif
        .cout(s_cout)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_wide (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .sum(w_sum),
`ifdef PIPELINED_ADDER_OVF_EN
        .ovf(w_ovf),
`endif
        .cout(w_cout)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic c, input logic s);
        res_t   r;
        longint ux, uy, sx, sy, full, sres;
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            full   = ux - uy;
            r.cout = (ux >= uy);
            sres   = sx - sy;
        end else begin
            full   = ux + uy + longint'(c);
            r.cout = (full >= 64'sd4294967296);
            sres   = sx + sy + longint'(c);
        end
        r.sum = full[31:0];
        r.ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        return r;
    endfunction

    res_t exp_q[$];
    int   in_cyc[$];
    int   out_cyc[$];
    res_t got_r;

    // Sample mid-cycle: valid&&ready seen here is the transfer at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (w_out_valid && w_out_ready) begin
                out_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    got_r = exp_q.pop_front();
                    check("wide_sum", 64'(w_sum), 64'(got_r.sum));
                    check("wide_cout", 64'(w_cout), 64'(got_r.cout));
`ifdef PIPELINED_ADDER_OVF_EN
                    check("wide_ovf", 64'(w_ovf), 64'(got_r.ovf));
`endif
                end
            end
            if (w_in_valid && w_in_ready) begin
                exp_q.push_back(model(w_a, w_b, w_cin, w_sub));
                in_cyc.push_back(cyc);
            end
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wide_random(input logic valid);
        w_a        = $urandom;
        w_b        = $urandom;
        w_cin      = 1'($urandom_range(0, 1));
        w_sub      = 1'($urandom_range(0, 1));
        w_in_valid = valid;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] held_sum;
    logic        held_cout;

    initial begin
        vecs[0]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[2]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4]  = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[5]  = '{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[6]  = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[7]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[8]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[10] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        rst = 1'b1;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0; s_out_ready = 1'b1;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_sub = 1'b0; w_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("reset_small_out_valid", 64'(s_out_valid), 0);
        check("reset_small_sum", 64'(s_sum), 0);
        check("reset_small_cout", 64'(s_cout), 0);
        check("reset_small_in_ready", 64'(s_in_ready), 1);
        check("reset_wide_out_valid", 64'(w_out_valid), 0);
        check("reset_wide_sum", 64'(w_sum), 0);
        check("reset_wide_in_ready", 64'(w_in_ready), 1);
`ifdef PIPELINED_ADDER_OVF_EN
        check("reset_small_ovf", 64'(s_ovf), 0);
`endif

        // Narrow table: exact 2-cycle latency, single result per op.
        for (int i = 0; i < 12; i++) begin
            s_a = vecs[i].a; s_b = vecs[i].b; s_cin = vecs[i].cin; s_sub = vecs[i].sub;
            s_in_valid = 1'b1;
            check("small_in_ready", 64'(s_in_ready), 1);
            tick();
            s_in_valid = 1'b0;
            check("small_latency_early", 64'(s_out_valid), 0);
            tick();
            check("small_out_valid", 64'(s_out_valid), 1);
            check("small_sum", 64'(s_sum), 64'(vecs[i].sum));
            check("small_cout", 64'(s_cout), 64'(vecs[i].cout));
`ifdef PIPELINED_ADDER_OVF_EN
            check("small_ovf", 64'(s_ovf), 64'(vecs[i].ovf));
`endif
            tick();
            check("small_no_duplicate", 64'(s_out_valid), 0);
        end

        // Back-to-back: 16 ops, results on consecutive cycles after exactly 4 cycles.
        in_cyc.delete(); out_cyc.delete();
        w_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_wide_random(1'b1);
            tick();
        end
        w_in_valid = 1'b0;
        repeat (10) tick();
        check("b2b_accepted", 64'(in_cyc.size()), 16);
        check("b2b_emitted", 64'(out_cyc.size()), 16);
        if (in_cyc.size() == 16 && out_cyc.size() == 16) begin
            check("b2b_latency", 64'(out_cyc[0] - in_cyc[0]), 4);
            check("b2b_consecutive", 64'(out_cyc[15] - out_cyc[0]), 15);
        end
        check("b2b_scoreboard_empty", 64'(exp_q.size()), 0);

        // Backpressure: pipeline fills with exactly STAGES ops, output held stable.
        in_cyc.delete(); out_cyc.delete();
        w_out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive_wide_random(1'b1);
            tick();
        end
        w_in_valid = 1'b0;
        check("bp_accepted", 64'(in_cyc.size()), 4);
        check("bp_in_ready_low", 64'(w_in_ready), 0);
        check("bp_out_valid", 64'(w_out_valid), 1);
        held_sum  = w_sum;
        held_cout = w_cout;
        repeat (3) tick();
        check("bp_sum_stable", 64'(w_sum), 64'(held_sum));
        check("bp_cout_stable", 64'(w_cout), 64'(held_cout));
        check("bp_out_valid_stable", 64'(w_out_valid), 1);
        w_out_ready = 1'b1;
        repeat (8) tick();
        check("bp_drained", 64'(out_cyc.size()), 4);
        check("bp_scoreboard_empty", 64'(exp_q.size()), 0);
        check("bp_in_ready_back", 64'(w_in_ready), 1);

        // Reset with three ops in flight: all flushed, none emitted later.
        in_cyc.delete(); out_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            drive_wide_random(1'b1);
            tick();
        end
        w_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 64'(w_out_valid), 0);
        check("midrst_sum", 64'(w_sum), 0);
        check("midrst_cout", 64'(w_cout), 0);
        check("midrst_in_ready", 64'(w_in_ready), 1);
        repeat (10) tick();
        check("midrst_no_emission", 64'(out_cyc.size()), 0);

        // Random traffic with random backpressure.
        in_cyc.delete(); out_cyc.delete();
        for (int i = 0; i < 400; i++) begin
            drive_wide_random(1'($urandom_range(0, 1)));
            w_out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;
        repeat (12) tick();
        check("random_count", 64'(out_cyc.size()), 64'(in_cyc.size()));
        check("random_scoreboard_empty", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry add/subtract unit with valid/ready handshake on both sides.
- Successor to the single-bit combinational adder cells: WIDTH-bit operands are split into STAGES equal chunks, one chunk added per pipeline stage, with carry registered between stages.
- Serves as the shared arithmetic datapath block; throughput is one operation per cycle when unstalled.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); latency in cycles; CHUNK = WIDTH/STAGES bits added per stage.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands a, b, cin, sub are valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  downstream accepts result this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; for sub, 1 means no borrow (a >= b unsigned).

Behaviour:
- Transfer on a port occurs in a cycle where valid && ready are both high at the rising edge.
- Stage k (0..STAGES-1) holds valid[k], the completed low (k+1)*CHUNK sum bits, the carry out of chunk k, and the unconsumed upper bits of a and effective b.
- Stage 0 adds chunk 0 of a and effective b plus the effective carry in.
  - effective b = sub ? ~b : b
  - effective carry in = sub ? 1 : cin
- Stage k>0 adds its chunk plus the registered carry from stage k-1.
- Bubble-collapsing ready chain:
  - ready[STAGES] = out_ready
  - ready[k] = !valid[k] || ready[k+1]
  - in_ready = ready[0], purely combinational; no combinational path from in_valid to in_ready.
- Stage k loads from stage k-1 (or from the inputs, for k=0) when ready[k] is high. Its valid becomes the upstream valid (or in_valid).
- Stage data registers hold their value when ready[k] is low.
- Outputs are driven directly from the last stage: out_valid = valid[STAGES-1], sum/cout from its registers.
- Latency is exactly STAGES cycles from input transfer to out_valid, with no stalls.
- Throughput is 1 per cycle while out_ready=1.
- Results leave in acceptance order; no reordering, drop or duplication.
- When out_valid=1 and out_ready=0:
  - sum/cout/out_valid stay stable until transfer.
  - Upstream stages keep filling bubbles; in_ready drops once every stage is valid.
- Reset:
  - All valid bits, sum and cout are cleared to 0 the cycle after rst is sampled high.
  - in_ready is 1 after reset.
  - Reset mid-operation flushes all in-flight results; none are emitted after reset.
  - While rst=1, in_ready is still computed from the cleared state, but no transfer takes effect.
- Wrap-around: sum is truncated to WIDTH bits; the overflowing carry appears only on cout.
- Boundaries:
  - STAGES=1 degenerates to a single registered adder.
  - STAGES=WIDTH gives a bit-serial-per-stage ripple.
  - WIDTH % STAGES != 0 must fail elaboration with $error.

Optional Feature:
- Macro: PIPELINED_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = signed two's-complement overflow of the full WIDTH operation, on the effective operands.
  - ovf = carry into MSB XOR carry out of MSB.
  - Registered alongside sum, reset to 0, stable under stall like sum.
- Undefined:
  - Port ovf does not exist.
  - No extra registers are inferred; all other behaviour is identical.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: a=0x0F, b=0x01, cin=0, sub=0 -> 2 cycles after transfer, sum=0x10, cout=0.
- WIDTH=8: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1; with OVF_EN, a=0x7F, b=0x01 -> sum=0x80, ovf=1.
- Subtract, WIDTH=8:
  - a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0.
  - a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
  - cin=1 is ignored in both cases.
- Back-to-back, WIDTH=32, STAGES=4: 16 random operand pairs on consecutive cycles, out_ready=1 -> 16 results on consecutive cycles starting 4 cycles after the first transfer, all equal to the reference model, in order.
- Backpressure: hold out_ready=0 while streaming -> in_ready falls after exactly STAGES accepted ops; out_valid/sum stable; on release, all results drain in order with none lost.
- Reset mid-flight: 3 ops in the pipeline, assert rst for 1 cycle -> the next cycle shows out_valid=0, sum=0, cout=0, in_ready=1; none of the 3 results is ever emitted.
